mips_multicycle_ctrl: RTL

Main control FSM of the multicycle MIPS datapath. It decodes the instruction opcode and sequences fetch/decode/execute/memory/writeback steps. It drives the PCWrite and Branch strobes consumed by the PC-enable logic (PCEn = PCWrite | (Branch & Zero)), plus all datapath mux selects and write enables. It is a Moore machine: every output is a pure function of the current state.

---
 rtl/mips_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Main control FSM of the multicycle MIPS datapath. Sequences the
// fetch / decode / execute / memory / writeback steps from the instruction
// opcode and drives every datapath mux select and write enable. The machine is
// Moore: each output is a pure function of the current state. The outputs are
// held in a register that is loaded with the decode of the state being entered,
// so they always equal the decode of State while staying glitch-free.
//
// Ports:
//   clk       in   1  rising-edge clock
//   reset     in   1  synchronous, active-high; forces state to FETCH
//   Op        in   6  opcode from the instruction register (used in DECODE/MEMADR)
//   PCWrite   out  1  unconditional PC update strobe
//   Branch    out  1  conditional PC update, qualified externally by Zero
//   IorD      out  1  memory address select (0 = PC, 1 = ALUOut)
//   MemWrite  out  1  memory write enable
//   IRWrite   out  1  instruction register load enable
//   RegDst    out  1  write register select (0 = rt, 1 = rd)
//   MemtoReg  out  1  writeback data select (0 = ALUOut, 1 = Data)
//   RegWrite  out  1  register file write enable
//   ALUSrcA   out  1  ALU A select (0 = PC, 1 = A)
//   ALUSrcB   out  2  ALU B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   ALUOp     out  2  00 add, 01 subtract, 10 funct-decoded
//   PCSrc     out  2  next-PC select (00 ALUResult, 01 ALUOut, 10 jump target)
//   State     out  4  current state encoding
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  state_t state_r;
  state_t next_state_s;
  ctrl_t  ctrl_r;

  // Moore output decode; anything not named for a state stays 0, including
  // the unused encodings 12-15.
  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b01;
        c.ir_write  = 1'b1;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
      end
      S_MEMADR, S_ADDIEXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.iord = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = 2'b10;
        c.pc_write = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Next-state logic; Op only matters in DECODE and MEMADR.
  always_comb begin
    next_state_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        if ((Op == OP_LW) || (Op == OP_SW)) begin
          next_state_s = S_MEMADR;
        end else if (Op == OP_RTYPE) begin
          next_state_s = S_EXECUTE;
        end else if (Op == OP_BEQ) begin
          next_state_s = S_BRANCH;
        end else if (Op == OP_ADDI) begin
          next_state_s = S_ADDIEXEC;
        end else if (Op == OP_J) begin
          next_state_s = S_JUMP;
        end else begin
          // Unsupported opcode: two-cycle no-op.
          next_state_s = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (Op == OP_LW) begin
          next_state_s = S_MEMRD;
        end else if (Op == OP_SW) begin
          next_state_s = S_MEMWR;
        end else begin
          // Opcode no longer a memory op: abandon rather than guess.
          next_state_s = S_FETCH;
        end
      end
      S_MEMRD: begin
        next_state_s = S_MEMWB;
      end
      S_EXECUTE: begin
        next_state_s = S_ALUWB;
      end
      S_ADDIEXEC: begin
        next_state_s = S_ADDIWB;
      end
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
        next_state_s = S_FETCH;
      end
      default: begin
        next_state_s = S_FETCH;
      end
    endcase
  end

  // State register plus output register loaded with the decode of the
  // state being entered, so outputs track State exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
      ctrl_r  <= decode_ctrl(S_FETCH);
    end else begin
      state_r <= next_state_s;
      ctrl_r  <= decode_ctrl(next_state_s);
    end
  end

  assign State    = state_r;
  assign PCWrite  = ctrl_r.pc_write;
  assign Branch   = ctrl_r.branch;
  assign IorD     = ctrl_r.iord;
  assign MemWrite = ctrl_r.mem_write;
  assign IRWrite  = ctrl_r.ir_write;
  assign RegDst   = ctrl_r.reg_dst;
  assign MemtoReg = ctrl_r.mem_to_reg;
  assign RegWrite = ctrl_r.reg_write;
  assign ALUSrcA  = ctrl_r.alu_src_a;
  assign ALUSrcB  = ctrl_r.alu_src_b;
  assign ALUOp    = ctrl_r.alu_op;
  assign PCSrc    = ctrl_r.pc_src;

endmodule
